// File: rtl/sra_pkg.sv
// Shared types and constants for the SRA magnitude-estimate datapath.
// Covers the op-code enums, the operand select codes and the control-word field layout.
package sra_pkg;

  localparam int W      = 16;
  localparam int NREG   = 5;
  localparam int CTRL_W = 27;

  typedef enum logic [1:0] {
    AU1_ADD = 2'b00,
    AU1_SUB = 2'b01,
    AU1_MAX = 2'b10,
    AU1_MIN = 2'b11
  } au1_op_e;

  typedef enum logic [1:0] {
    AU2_ABS  = 2'b00,
    AU2_ASR1 = 2'b01,
    AU2_ASR3 = 2'b10,
    AU2_PASS = 2'b11
  } au2_op_e;

  localparam logic [2:0] SEL_R0   = 3'd0;
  localparam logic [2:0] SEL_R1   = 3'd1;
  localparam logic [2:0] SEL_R2   = 3'd2;
  localparam logic [2:0] SEL_R3   = 3'd3;
  localparam logic [2:0] SEL_R4   = 3'd4;
  localparam logic [2:0] SEL_IN0  = 3'd5;
  localparam logic [2:0] SEL_IN1  = 3'd6;
  localparam logic [2:0] SEL_ZERO = 3'd7;

  // Control word: {read[4:0], write[4:0], c_AU1[1:0], c_AU2[1:0], ctrl_bus[12:0]}
  localparam int SRC_LSB   = 0;
  localparam int SEL_X_LSB = 4;
  localparam int SEL_B_LSB = 7;
  localparam int SEL_A_LSB = 10;
  localparam int C2_LSB    = 13;
  localparam int C1_LSB    = 15;
  localparam int WR_LSB    = 17;
  localparam int RD_LSB    = 22;

  function automatic logic [W-1:0] pick_operand(
    input logic [2:0]              sel,
    input logic [NREG-1:0][W-1:0]  regs,
    input logic [W-1:0]            in0,
    input logic [W-1:0]            in1
  );
    logic [W-1:0] v;
    v = '0;
    case (sel)
      SEL_R0:  v = regs[0];
      SEL_R1:  v = regs[1];
      SEL_R2:  v = regs[2];
      SEL_R3:  v = regs[3];
      SEL_R4:  v = regs[4];
      SEL_IN0: v = in0;
      SEL_IN1: v = in1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sra_alu.sv
// Combinational arithmetic units: AU1 (binary add/sub/max/min) and AU2 (abs/arith shift/pass).
// All results wrap at W bits; |most-negative| stays most-negative.
module sra_alu
  import sra_pkg::*;
(
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_x,
  input  au1_op_e      i_op1,
  input  au2_op_e      i_op2,
  output logic [W-1:0] o_au1,
  output logic [W-1:0] o_au2
);

  always_comb begin
    o_au1 = '0;
    case (i_op1)
      AU1_ADD: o_au1 = i_a + i_b;
      AU1_SUB: o_au1 = i_a - i_b;
      AU1_MAX: o_au1 = ($signed(i_a) > $signed(i_b)) ? i_a : i_b;
      AU1_MIN: o_au1 = ($signed(i_a) < $signed(i_b)) ? i_a : i_b;
      default: o_au1 = '0;
    endcase
  end

  always_comb begin
    o_au2 = '0;
    case (i_op2)
      AU2_ABS:  o_au2 = i_x[W-1] ? (~i_x + 1'b1) : i_x;
      AU2_ASR1: o_au2 = $signed(i_x) >>> 1;
      AU2_ASR3: o_au2 = $signed(i_x) >>> 3;
      AU2_PASS: o_au2 = i_x;
      default:  o_au2 = '0;
    endcase
  end

endmodule

// File: rtl/sra_datapath_pipe.sv
// Micro-coded SRA datapath: 5-entry register file, operand muxes and write-back muxes around sra_alu.
// Every field of the 27-bit control word is consumed in the same clock it is presented.
module sra_datapath_pipe
  import sra_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [W-1:0]  In0,
  input  logic signed [W-1:0]  In1,
  input  logic [CTRL_W-1:0]    Control,
  output logic signed [W-1:0]  OUT
);

  logic [NREG-1:0][W-1:0] r_rf;
  logic [NREG-1:0][W-1:0] w_gated;
  logic [NREG-1:0]        w_read;
  logic [NREG-1:0]        w_write;
  logic [NREG-2:0]        w_src;
  logic [2:0]             w_sel_a;
  logic [2:0]             w_sel_b;
  logic [2:0]             w_sel_x;
  au1_op_e                w_op1;
  au2_op_e                w_op2;
  logic [W-1:0]           w_a;
  logic [W-1:0]           w_b;
  logic [W-1:0]           w_x;
  logic [W-1:0]           w_au1;
  logic [W-1:0]           w_au2;

  assign w_read  = Control[RD_LSB +: NREG];
  assign w_write = Control[WR_LSB +: NREG];
  assign w_op1   = au1_op_e'(Control[C1_LSB +: 2]);
  assign w_op2   = au2_op_e'(Control[C2_LSB +: 2]);
  assign w_sel_a = Control[SEL_A_LSB +: 3];
  assign w_sel_b = Control[SEL_B_LSB +: 3];
  assign w_sel_x = Control[SEL_X_LSB +: 3];
  assign w_src   = Control[SRC_LSB +: NREG-1];

  // A register whose read enable is low contributes zero to every operand bus.
  always_comb begin
    w_gated = '0;
    for (int i = 0; i < NREG; i++) begin
      if (w_read[i]) w_gated[i] = r_rf[i];
    end
  end

  assign w_a = pick_operand(w_sel_a, w_gated, In0, In1);
  assign w_b = pick_operand(w_sel_b, w_gated, In0, In1);
  assign w_x = pick_operand(w_sel_x, w_gated, In0, In1);

  sra_alu u_alu (
    .i_a   (w_a),
    .i_b   (w_b),
    .i_x   (w_x),
    .i_op1 (w_op1),
    .i_op2 (w_op2),
    .o_au1 (w_au1),
    .o_au2 (w_au2)
  );

  // R4 is hard-wired to AU1; R0..R3 pick AU1 or AU2 per their source bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf <= '0;
    end else begin
      for (int i = 0; i < NREG-1; i++) begin
        if (w_write[i]) r_rf[i] <= w_src[i] ? w_au2 : w_au1;
      end
      if (w_write[NREG-1]) r_rf[NREG-1] <= w_au1;
    end
  end

  assign OUT = r_rf[NREG-1];

endmodule

// File: tb/tb_sra_datapath_pipe.sv
// Directed self-checking bench for sra_datapath_pipe; observes the register file through OUT (R4).
module tb_sra_datapath_pipe;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] In0;
  logic signed [15:0] In1;
  logic [26:0]        Control;
  logic signed [15:0] OUT;

  int checks = 0;
  int errors = 0;

  logic [26:0] slot [5];

  sra_datapath_pipe dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .In0     (In0),
    .In1     (In1),
    .Control (Control),
    .OUT     (OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [26:0] cw(
    input logic [4:0] rd, input logic [4:0] wr,
    input logic [1:0] o1, input logic [1:0] o2,
    input logic [2:0] a,  input logic [2:0] b, input logic [2:0] x,
    input logic [3:0] src
  );
    return {rd, wr, o1, o2, a, b, x, src};
  endfunction

  task automatic step(input logic [26:0] c);
    Control = c;
    @(posedge clk);
    #1;
  endtask

  // R4 <= Rsel + 0, then OUT shows the selected register.
  task automatic peek(input logic [2:0] sel, output logic signed [15:0] v);
    step(cw(5'h1f, 5'b10000, 2'd0, 2'd3, sel, 3'd7, 3'd7, 4'd0));
    v = OUT;
  endtask

  task automatic load_abs_in0(input int idx, input logic signed [15:0] val);
    In0 = val;
    step(cw(5'h1f, 5'(1 << idx), 2'd0, 2'd0, 3'd7, 3'd7, 3'd5, 4'hf));
  endtask

  task automatic apply_reset();
    Control = '0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check(input string name, input logic signed [15:0] got,
                       input logic signed [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    logic signed [15:0] v;
    apply_reset();
    load_abs_in0(0, 16'sd77);
    In0 = 16'sd5;
    step(cw(5'h1f, 5'b10000, 2'd0, 2'd0, 3'd5, 3'd7, 3'd5, 4'hf));
    check("reset_pre", OUT, 16'sd5);
    Control = cw(5'h1f, 5'h1f, 2'd0, 2'd0, 3'd5, 3'd5, 3'd5, 4'hf);
    #3 rst_n = 1'b0;
    #1 check("reset_async", OUT, 16'sd0);
    @(posedge clk);
    #1 check("reset_held", OUT, 16'sd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      peek(3'(i), v);
      check($sformatf("reset_r%0d", i), v, 16'sd0);
    end
  endtask

  task automatic test_abs_load();
    logic signed [15:0] v;
    load_abs_in0(0, 16'sd77);
    peek(3'd0, v);
    check("abs_r0", v, 16'sd77);
    In1 = -16'sd50;
    step(cw(5'h1f, 5'b00010, 2'd0, 2'd0, 3'd7, 3'd7, 3'd6, 4'hf));
    peek(3'd1, v);
    check("abs_r1", v, 16'sd50);
    // Same-cycle write of R0 while reading it: the read must see the old 77.
    In0 = 16'sd5;
    step(cw(5'h1f, 5'b10001, 2'd0, 2'd0, 3'd0, 3'd7, 3'd5, 4'b0001));
    check("no_bypass", OUT, 16'sd77);
    peek(3'd0, v);
    check("no_bypass_r0", v, 16'sd5);
  endtask

  task automatic run_one(input logic signed [15:0] a, input logic signed [15:0] b,
                         input logic signed [15:0] exp, input string name);
    apply_reset();
    In0 = a;
    In1 = b;
    for (int c = 0; c < 7; c++) step(slot[c % 5]);
    check(name, OUT, exp);
  endtask

  task automatic test_sra();
    // 77,-50: x=77 y=50; 77-9+25=93; max(93,77)=93
    run_one(16'sd77, -16'sd50, 16'sd93, "sra_77_m50");
    // -6,8: x=8 y=6; 8-1+3=10; max(10,8)=10
    run_one(-16'sd6, 16'sd8, 16'sd10, "sra_m6_8");
  endtask

  task automatic test_wrap();
    logic signed [15:0] v;
    In0 = 16'sd32767;
    In1 = 16'sd1;
    step(cw(5'h1f, 5'b10000, 2'd0, 2'd3, 3'd5, 3'd6, 3'd7, 4'd0));
    check("add_wrap", OUT, -16'sd32768);
    load_abs_in0(0, -16'sd32768);
    peek(3'd0, v);
    check("abs_min", v, -16'sd32768);
    In0 = -16'sd9;
    step(cw(5'h1f, 5'b00010, 2'd0, 2'd2, 3'd7, 3'd7, 3'd5, 4'hf));
    peek(3'd1, v);
    check("asr3_m9", v, -16'sd2);
    In0 = -16'sd5;
    In1 = 16'sd3;
    step(cw(5'h1f, 5'b10000, 2'd3, 2'd3, 3'd5, 3'd6, 3'd7, 4'd0));
    check("min_signed", OUT, -16'sd5);
    step(cw(5'h1f, 5'b10000, 2'd1, 2'd3, 3'd6, 3'd5, 3'd7, 4'd0));
    check("sub", OUT, 16'sd8);
  endtask

  task automatic test_gating();
    logic signed [15:0] v;
    apply_reset();
    load_abs_in0(0, 16'sd77);
    In1 = -16'sd50;
    step(cw(5'h1f, 5'b00010, 2'd0, 2'd0, 3'd7, 3'd7, 3'd6, 4'hf));
    step(cw(5'b11110, 5'b10000, 2'd0, 2'd3, 3'd0, 3'd1, 3'd7, 4'd0));
    check("gate_r0", OUT, 16'sd50);
    In0 = 16'sd1000;
    step(cw(5'h1f, 5'b00000, 2'd1, 2'd0, 3'd5, 3'd1, 3'd5, 4'hf));
    check("no_write_out", OUT, 16'sd50);
    peek(3'd0, v);
    check("no_write_r0", v, 16'sd77);
    // Unknown op/select fields of the idle AU and unused source bits must not matter.
    In0 = -16'sd12;
    step(cw(5'h1f, 5'b00001, 2'bxx, 2'd0, 3'bxxx, 3'bxxx, 3'd5, 4'bxxx1));
    peek(3'd0, v);
    check("x_fields", v, 16'sd12);
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] pa [3];
    logic signed [15:0] pb [3];
    pa = '{16'sd77, 16'sd154, 16'sd231};
    pb = '{-16'sd50, -16'sd100, -16'sd150};
    apply_reset();
    for (int n = 0; n < 17; n++) begin
      In0 = pa[(n / 5 > 2) ? 2 : n / 5];
      In1 = pb[(n / 5 > 2) ? 2 : n / 5];
      step(slot[n % 5]);
      // 154,-100: 154-19+50=185; 231,-150: 231-28+75=278
      if (n == 6)  check("pipe_out0", OUT, 16'sd93);
      if (n == 10) check("pipe_hold", OUT, 16'sd93);
      if (n == 11) check("pipe_out1", OUT, 16'sd185);
      if (n == 15) check("pipe_hold2", OUT, 16'sd185);
      if (n == 16) check("pipe_out2", OUT, 16'sd278);
    end
  endtask

  initial begin
    rst_n   = 1'b1;
    In0     = '0;
    In1     = '0;
    Control = '0;
    // Modulo-5 schedule; each slot carries work for two overlapping pairs.
    slot[0] = cw(5'h1f, 5'b01001, 2'd0, 2'd0, 3'd3, 3'd1, 3'd5, 4'b0001);
    slot[1] = cw(5'h1f, 5'b10010, 2'd2, 2'd0, 3'd3, 3'd2, 3'd6, 4'b0010);
    slot[2] = cw(5'h1f, 5'b00100, 2'd2, 2'd3, 3'd0, 3'd1, 3'd7, 4'b0000);
    slot[3] = cw(5'h1f, 5'b01001, 2'd3, 2'd2, 3'd0, 3'd1, 3'd2, 4'b0001);
    slot[4] = cw(5'h1f, 5'b01010, 2'd1, 2'd1, 3'd2, 3'd0, 3'd3, 4'b0010);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("por_out", OUT, 16'sd0);
    test_reset();
    test_abs_load();
    test_sra();
    test_wrap();
    test_gating();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
